pwr_req_ctrl: RTL

- Initiator side of the I2C power-management handshake.
- Accepts software power-state commands from the register bank and waits for the I2C core to go quiescent before requesting a low-power state.
- Drives the request/wake-enable inputs of the power manager and tracks its acknowledge, timing out if no acknowledge arrives.
- Reports done/error pulses and a sticky wake interrupt to the register bank.

---
 rtl/i2c_pwr_pkg.sv | 26 ++
 rtl/pwr_sat_counter.sv | 29 ++
 rtl/pwr_req_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pwr_pkg.sv
// Shared power-management definitions: 2-bit power-state codes (also used by
// the power manager) and the state encoding of the request controller.
package i2c_pwr_pkg;

  localparam logic [1:0] PWR_ACTIVE = 2'b00;
  localparam logic [1:0] PWR_IDLE   = 2'b01;
  localparam logic [1:0] PWR_SLEEP  = 2'b10;
  localparam logic [1:0] PWR_OFF    = 2'b11;

  localparam int DEF_ACK_TIMEOUT    = 2048;
  localparam int DEF_QUIESCE_CYCLES = 16;
  localparam int DEF_CNT_W          = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUIESCE  = 2'd1,
    ST_REQUEST  = 2'd2,
    ST_WAIT_ACK = 2'd3
  } req_state_e;

  // True for any state other than ACTIVE.
  function automatic logic is_low_power(input logic [1:0] pwr);
    return pwr != PWR_ACTIVE;
  endfunction

endpackage

// File: rtl/pwr_sat_counter.sv
// Saturating cycle counter with synchronous clear and a terminal-count
// compare; one instance is shared by the quiesce and ack-wait phases.
module pwr_sat_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             at_tc
);

  logic [CNT_W-1:0] count_q;

  // Clear has priority; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign at_tc = (count_q == tc_val);

endmodule

// File: rtl/pwr_req_ctrl.sv
// Initiator side of the I2C power-management handshake: waits for the core to
// go quiet, requests a power state, tracks the ack with a timeout and reports
// done/error pulses plus a sticky wake interrupt.
//
// Command handshake: a command transfers on the rising clock edge where
// i_cmd_valid && o_cmd_ready; o_cmd_ready is high only while the FSM is idle
// and a valid seen while it is low is dropped (no queueing).
module pwr_req_ctrl
  import i2c_pwr_pkg::*;
#(
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
  parameter int QUIESCE_CYCLES = DEF_QUIESCE_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd_state,
  output logic       o_cmd_ready,
  input  logic       i_core_busy,
  output logic [1:0] o_power_state_req,
  output logic       o_wake_up_en,
  output logic       o_wake_kick,
  input  logic [1:0] i_power_state_ack,
  input  logic       i_wake_up_event,
  input  logic       i_in_low_power,
  output logic [1:0] o_status_state,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err_timeout,
  output logic       o_wake_irq,
  input  logic       i_wake_irq_clr
);

  req_state_e       state_q, state_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       req_d;
  logic             wake_en_d, done_d, err_d, irq_d;
  logic             cnt_clr, cnt_en, cnt_at_tc, kick;
  logic [CNT_W-1:0] cnt_tc;

  // Terminal count depends on which phase currently owns the counter.
  assign cnt_tc = (state_q == ST_QUIESCE) ? CNT_W'(QUIESCE_CYCLES - 1)
                                          : CNT_W'(ACK_TIMEOUT - 1);

  pwr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (i_sys_clk),
    .rst_n  (i_rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (cnt_tc),
    .at_tc  (cnt_at_tc)
  );

  // State register plus all registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= ST_IDLE;
      target_q          <= PWR_ACTIVE;
      o_power_state_req <= PWR_ACTIVE;
      o_wake_up_en      <= 1'b0;
      o_done            <= 1'b0;
      o_err_timeout     <= 1'b0;
      o_wake_irq        <= 1'b0;
      o_status_state    <= PWR_ACTIVE;
    end else begin
      state_q           <= state_d;
      target_q          <= target_d;
      o_power_state_req <= req_d;
      o_wake_up_en      <= wake_en_d;
      o_done            <= done_d;
      o_err_timeout     <= err_d;
      o_wake_irq        <= irq_d;
      o_status_state    <= i_power_state_ack;
    end
  end

  // Next-state logic, counter control and next values of registered outputs.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    req_d     = o_power_state_req;
    wake_en_d = o_wake_up_en;
    done_d    = 1'b0;
    err_d     = 1'b0;
    irq_d     = o_wake_irq && !i_wake_irq_clr;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    kick      = 1'b0;

    if (i_wake_up_event) begin
      irq_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (i_cmd_valid) begin
          target_d = i_cmd_state;
          if (i_cmd_state == o_status_state) begin
            done_d = 1'b1;
          end else if (i_cmd_state == PWR_ACTIVE) begin
            state_d = ST_REQUEST;
          end else begin
            state_d = ST_QUIESCE;
          end
        end
      end
      ST_QUIESCE: begin
        if (i_wake_up_event) begin
          state_d = ST_IDLE;
        end else if (i_core_busy) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_at_tc) begin
            state_d = ST_REQUEST;
          end
        end
      end
      ST_REQUEST: begin
        cnt_clr = 1'b1;
        req_d   = target_q;
        if (target_q == PWR_ACTIVE) begin
          kick = 1'b1;
          if (o_status_state == PWR_OFF) begin
            wake_en_d = 1'b1;
          end
        end
        // A wake arriving while a low-power request is being issued aborts it.
        if (i_wake_up_event && (target_q != PWR_ACTIVE)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        cnt_en = 1'b1;
        if ((i_power_state_ack == target_q) ||
            (i_wake_up_event && (target_q == PWR_ACTIVE))) begin
          done_d    = 1'b1;
          wake_en_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (i_wake_up_event) begin
          wake_en_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_at_tc) begin
          err_d     = 1'b1;
          req_d     = o_status_state;
          wake_en_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A wake always pins the request at ACTIVE so the manager stays awake.
    if (i_wake_up_event) begin
      req_d = PWR_ACTIVE;
    end
  end

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_wake_kick = kick;

`ifndef SYNTHESIS
  // The manager's low-power flag lags its ack by one cycle, like o_status_state.
  low_power_consistent : assert property (@(posedge i_sys_clk) disable iff (!i_rst_n)
    i_in_low_power == is_low_power(o_status_state));
`endif

endmodule
